// File: rtl/piso_rr_sched.sv
// Round-robin scheduler feeding one shared wide-to-narrow serializer.
// Granted words are emitted LSB slice first on a valid/ready beat stream.
module piso_rr_sched #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [NUM_REQ-1:0]                REQ_VALID,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]                REQ_READY,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [DATA_OUT_WIDTH-1:0]         OUT_DATA,
    output logic [ID_WIDTH-1:0]               OUT_ID,
    output logic                              OUT_LAST,
    output logic                              BUSY
);

    localparam int NUM_BEATS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 2) ? $clog2(NUM_BEATS) : 1;

    generate
        if ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0 || NUM_BEATS < 2) begin : gBadWidths
            $error("piso_rr_sched: DATA_IN_WIDTH must be a multiple (>=2x) of DATA_OUT_WIDTH");
        end
        if (NUM_REQ < 2 || ID_WIDTH != $clog2(NUM_REQ)) begin : gBadIdWidth
            $error("piso_rr_sched: need NUM_REQ>=2 and ID_WIDTH == clog2(NUM_REQ)");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                     state_q;
    logic [DATA_IN_WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [ID_WIDTH-1:0]        id_q;
    logic [ID_WIDTH-1:0]        ptr_q;

    logic [DATA_IN_WIDTH-1:0]   reqWord [NUM_REQ];
    logic                       grantValid;
    logic [ID_WIDTH-1:0]        grantIdx;
    logic [ID_WIDTH-1:0]        candIdx;
    logic                       grantWindow;
    logic                       grantFire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : gSplit
        assign reqWord[i] = REQ_DATA[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end

    // Scan starting just after the last winner so every requester gets a turn.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!grantValid && REQ_VALID[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    assign BUSY      = (state_q == SHIFT);
    assign OUT_VALID = BUSY;
    assign OUT_DATA  = BUSY ? shift_q[DATA_OUT_WIDTH-1:0] : '0;
    assign OUT_ID    = BUSY ? id_q : '0;
    assign OUT_LAST  = BUSY && (cnt_q == '0);

    // A new word may only be taken while idle or as the final beat leaves.
    assign grantWindow = !RESET && (!BUSY || (OUT_READY && OUT_LAST));
    assign grantFire   = grantWindow && grantValid;
    assign REQ_READY   = grantFire ? (NUM_REQ'(1) << grantIdx) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
        end else if (grantFire) begin
            state_q <= SHIFT;
            shift_q <= reqWord[grantIdx];
            cnt_q   <= CNT_W'(NUM_BEATS - 1);
            id_q    <= grantIdx;
            ptr_q   <= grantIdx;
        end else if (BUSY && OUT_READY) begin
            if (cnt_q == '0) begin
                state_q <= IDLE;
                shift_q <= '0;
                id_q    <= '0;
            end else begin
                shift_q <= shift_q >> DATA_OUT_WIDTH;
                cnt_q   <= cnt_q - 1'b1;
            end
        end
    end

endmodule
